// File: rtl/game_state_tx.sv
// Kart state link transmitter: snapshots the local player state on each frame trigger and
// serialises it as a fixed-length AXI-Stream byte packet.
// Optional feature macro: GAME_TX_CHECKSUM_EN appends an XOR checksum byte (bytes 1..7).
module game_state_tx #(
    parameter logic [7:0]  HEADER = 8'hA5,
    parameter int unsigned DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send_trig_i,
    input  logic [10:0]       player_x_i,
    input  logic [10:0]       player_y_i,
    input  logic [8:0]        player_dir_i,
    input  logic [2:0]        game_stat_i,
    input  logic              rst_req_i,
    input  logic              m_tready_i,
    output logic              m_tvalid_o,
    output logic [7:0]        m_tdata_o,
    output logic              m_tlast_o,
    output logic              busy_o,
    output logic [3:0]        seq_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

`ifdef GAME_TX_CHECKSUM_EN
    localparam logic [3:0] LastIdx = 4'd8;
`else
    localparam logic [3:0] LastIdx = 4'd7;
`endif

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e            state_q;
    logic [3:0]        idx_q;
    logic [10:0]       x_q;
    logic [10:0]       y_q;
    logic [8:0]        dir_q;
    logic [2:0]        stat_q;
    logic              flag_q;
    logic [3:0]        seq_q;
    logic              pending_q;
    logic              rst_flag_req_q;
    logic [DROP_W-1:0] drop_cnt_q;
    logic              tvalid_q;
    logic [7:0]        tdata_q;
    logic              tlast_q;

    logic [3:0]        idx_nxt;
    logic [7:0]        next_byte;
    logic              accept;
    logic              last_accept;
    logic              start;

    // Next byte to present after an accept, taken from the latched snapshot.
    always_comb begin
        idx_nxt   = idx_q + 4'd1;
        next_byte = 8'h00;
        case (idx_nxt)
            4'd1:    next_byte = {5'b0, x_q[10:8]};
            4'd2:    next_byte = x_q[7:0];
            4'd3:    next_byte = {5'b0, y_q[10:8]};
            4'd4:    next_byte = y_q[7:0];
            4'd5:    next_byte = {7'b0, dir_q[8]};
            4'd6:    next_byte = dir_q[7:0];
            4'd7:    next_byte = {seq_q, flag_q, stat_q};
`ifdef GAME_TX_CHECKSUM_EN
            4'd8:    next_byte = {5'b0, x_q[10:8]} ^ x_q[7:0] ^ {5'b0, y_q[10:8]} ^ y_q[7:0]
                                 ^ {7'b0, dir_q[8]} ^ dir_q[7:0] ^ {seq_q, flag_q, stat_q};
`endif
            default: next_byte = 8'h00;
        endcase
    end

    // Handshake decode; a pending trigger restarts straight off the last-byte accept.
    always_comb begin
        accept      = tvalid_q && m_tready_i;
        last_accept = accept && (idx_q == LastIdx);
        start       = ((state_q == StIdle) && (send_trig_i || pending_q))
                      || (last_accept && pending_q);
    end

    // Packet FSM with registered stream outputs, snapshot and trigger bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            idx_q          <= 4'd0;
            x_q            <= 11'd0;
            y_q            <= 11'd0;
            dir_q          <= 9'd0;
            stat_q         <= 3'd0;
            flag_q         <= 1'b0;
            seq_q          <= 4'd0;
            pending_q      <= 1'b0;
            rst_flag_req_q <= 1'b0;
            drop_cnt_q     <= '0;
            tvalid_q       <= 1'b0;
            tdata_q        <= 8'h00;
            tlast_q        <= 1'b0;
        end else begin
            // A trigger while busy (including the last-accept cycle) queues or is dropped.
            if ((state_q == StSend) && send_trig_i) begin
                if (pending_q) begin
                    if (drop_cnt_q != '1) begin
                        drop_cnt_q <= drop_cnt_q + {{(DROP_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    pending_q <= 1'b1;
                end
            end

            if (start) begin
                state_q        <= StSend;
                idx_q          <= 4'd0;
                x_q            <= player_x_i;
                y_q            <= player_y_i;
                dir_q          <= player_dir_i;
                stat_q         <= game_stat_i;
                flag_q         <= rst_flag_req_q | rst_req_i;
                rst_flag_req_q <= 1'b0;
                seq_q          <= seq_q + 4'd1;
                pending_q      <= 1'b0;
                tvalid_q       <= 1'b1;
                tdata_q        <= HEADER;
                tlast_q        <= 1'b0;
            end else begin
                if (rst_req_i) begin
                    rst_flag_req_q <= 1'b1;
                end
                if ((state_q == StSend) && accept) begin
                    if (last_accept) begin
                        state_q  <= StIdle;
                        tvalid_q <= 1'b0;
                        tdata_q  <= 8'h00;
                        tlast_q  <= 1'b0;
                    end else begin
                        idx_q   <= idx_nxt;
                        tdata_q <= next_byte;
                        tlast_q <= (idx_nxt == LastIdx);
                    end
                end
            end
        end
    end

    assign m_tvalid_o = tvalid_q;
    assign m_tdata_o  = tdata_q;
    assign m_tlast_o  = tlast_q;
    assign busy_o     = (state_q != StIdle);
    assign seq_o      = seq_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_game_state_tx.sv
// Bench for game_state_tx: directed packet/stall/reset cases plus randomized traffic,
// all checked against a packet-level reference model.
module tb_game_state_tx;

`ifdef GAME_TX_CHECKSUM_EN
    localparam int PktLen = 9;
`else
    localparam int PktLen = 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        send_trig;
    logic [10:0] player_x;
    logic [10:0] player_y;
    logic [8:0]  player_dir;
    logic [2:0]  game_stat;
    logic        rst_req;
    logic        m_tready;
    logic        m_tvalid;
    logic [7:0]  m_tdata;
    logic        m_tlast;
    logic        busy;
    logic [3:0]  seq;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    game_state_tx dut (
        .clk         (clk),
        .rst         (rst),
        .send_trig_i (send_trig),
        .player_x_i  (player_x),
        .player_y_i  (player_y),
        .player_dir_i(player_dir),
        .game_stat_i (game_stat),
        .rst_req_i   (rst_req),
        .m_tready_i  (m_tready),
        .m_tvalid_o  (m_tvalid),
        .m_tdata_o   (m_tdata),
        .m_tlast_o   (m_tlast),
        .busy_o      (busy),
        .seq_o       (seq),
        .drop_cnt_o  (drop_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the packet being sent as a byte array and a cursor into it.
    logic [7:0] m_pkt [PktLen];
    int         m_pos;
    bit         m_in_pkt;
    bit         m_pend;
    bit         m_req;
    logic [3:0] m_seq;
    int         m_drop;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic build_pkt(input bit flag);
        logic [7:0] cs;
        m_pkt[0] = 8'hA5;
        m_pkt[1] = 8'(player_x / 256);
        m_pkt[2] = 8'(player_x % 256);
        m_pkt[3] = 8'(player_y / 256);
        m_pkt[4] = 8'(player_y % 256);
        m_pkt[5] = 8'(player_dir / 256);
        m_pkt[6] = 8'(player_dir % 256);
        m_pkt[7] = 8'(m_seq * 16 + (flag ? 8 : 0) + game_stat);
        if (PktLen == 9) begin
            cs = 8'h00;
            for (int i = 1; i < 8; i++) cs = cs ^ m_pkt[i];
            m_pkt[PktLen-1] = cs;
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_update();
        bit acc, lastacc, start;
        if (rst) begin
            m_in_pkt = 0; m_pend = 0; m_req = 0; m_seq = 4'd0; m_drop = 0; m_pos = 0;
        end else begin
            acc     = m_in_pkt && m_tready;
            lastacc = acc && (m_pos == PktLen - 1);
            start   = (!m_in_pkt && (send_trig || m_pend)) || (lastacc && m_pend);
            if (m_in_pkt && send_trig) begin
                if (m_pend) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_pend = 1;
                end
            end
            if (start) begin
                m_seq = m_seq + 4'd1;
                build_pkt(m_req || rst_req);
                m_req = 0; m_pend = 0; m_pos = 0; m_in_pkt = 1;
            end else begin
                if (rst_req) m_req = 1;
                if (acc) begin
                    if (lastacc) m_in_pkt = 0;
                    else m_pos++;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        check_eq("tvalid", 32'(m_tvalid), 32'(m_in_pkt));
        check_eq("busy", 32'(busy), 32'(m_in_pkt));
        check_eq("seq", 32'(seq), 32'(m_seq));
        check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        check_eq("tlast", 32'(m_tlast), 32'(m_in_pkt && (m_pos == PktLen - 1)));
        if (m_in_pkt) check_eq("tdata", 32'(m_tdata), 32'(m_pkt[m_pos]));
    endtask

    // Inputs are driven just after a falling edge; outputs are checked at the next one.
    task automatic tick();
        model_update();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle_inputs();
        send_trig = 0; rst_req = 0; rst = 0;
    endtask

    logic [7:0] exp1 [8];
    logic [7:0] got1 [PktLen];
    int         ngot;
    int         guard;

    initial begin
        exp1[0] = 8'hA5; exp1[1] = 8'h00; exp1[2] = 8'h64; exp1[3] = 8'h00;
        exp1[4] = 8'h64; exp1[5] = 8'h00; exp1[6] = 8'h5A; exp1[7] = 8'h10;

        rst = 1; send_trig = 0; rst_req = 0; m_tready = 1;
        player_x = 11'd100; player_y = 11'd100; player_dir = 9'd90; game_stat = 3'd0;
        @(negedge clk);
        tick();
        tick();
        check_eq("reset_tdata", 32'(m_tdata), 32'h0);

        // Case 1: single packet, tready always high.
        rst = 0; send_trig = 1;
        tick();
        send_trig = 0;
        ngot = 0;
        for (int i = 0; i < PktLen; i++) begin
            got1[i] = m_tdata;
            ngot++;
            tick();
        end
        for (int i = 0; i < 8; i++) check_eq("case1_byte", 32'(got1[i]), 32'(exp1[i]));
`ifdef GAME_TX_CHECKSUM_EN
        check_eq("case2_csum", 32'(got1[8]), 32'h4A);
`endif
        check_eq("case1_seq", 32'(seq), 32'd1);
        check_eq("case1_idle", 32'(busy), 32'd0);

        // Case 3: stall pattern 1,0,0,1,...; model checks hold and no bubbles.
        send_trig = 1; m_tready = 1;
        tick();
        send_trig = 0;
        for (int i = 0; i < 4 * PktLen; i++) begin
            m_tready = ((i % 3) == 0);
            tick();
        end
        m_tready = 1;
        repeat (2) tick();

        // Case 5: rst_req while busy goes to the following packet only.
        send_trig = 1;
        tick();
        send_trig = 0; rst_req = 1;
        tick();
        rst_req = 0;
        repeat (PktLen) tick();
        check_eq("case5_flag_first", 32'(m_pkt[7][3]), 32'(0));

        // Case 6: reset mid-packet, then a fresh packet.
        send_trig = 1;
        tick();
        send_trig = 0;
        repeat (4) tick();
        rst = 1;
        tick();
        rst = 0;
        check_eq("case6_tvalid", 32'(m_tvalid), 32'd0);
        check_eq("case6_seq", 32'(seq), 32'd0);
        send_trig = 1;
        tick();
        send_trig = 0;
        check_eq("case6_header", 32'(m_tdata), 32'hA5);
        guard = 0;
        while (m_tvalid && guard < 100) begin
            tick();
            guard++;
        end
        check_eq("case6_done", 32'(guard < 100), 32'd1);

        // Randomized traffic: triggers, stalls, reset requests and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            send_trig  = ($urandom_range(0, 5) == 0);
            rst_req    = ($urandom_range(0, 19) == 0);
            m_tready   = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 299) == 0);
            player_x   = 11'($urandom);
            player_y   = 11'($urandom);
            player_dir = 9'($urandom);
            game_stat  = 3'($urandom);
            tick();
        end
        idle_inputs();
        m_tready = 1;
        repeat (3 * PktLen) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
